debug_program_loader: RTL and testbench

- Sits directly downstream of the debug UART receiver and upstream of the MIPS instruction memory and pipeline control in top_modular.
- Consumes received bytes: command bytes and program words (4 bytes per word, LSB first).
- Writes program words into instruction memory until the HALT word (opcode bits [31:26] all ones).
- Then gates the pipeline in continuous or step-by-step mode.

---
 rtl/debug_pkg.sv | 23 ++
 rtl/word_assembler.sv | 56 +++++
 rtl/debug_program_loader.sv | 171 +++++++++++++++++
 tb/tb_debug_program_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants for the debug program loader: command bytes, HALT opcode, state encodings.
package debug_pkg;

  localparam int unsigned STATE_WIDTH = 3;

  localparam logic [7:0] CMD_START        = 8'h01;
  localparam logic [7:0] CMD_CONTINUOUS   = 8'h02;
  localparam logic [7:0] CMD_STEP_BY_STEP = 8'h03;
  localparam logic [7:0] CMD_REPROGRAM    = 8'h05;
  localparam logic [7:0] CMD_STEP         = 8'h06;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE        = 3'd0,
    ST_PROGRAMMING = 3'd1,
    ST_WAIT_MODE   = 3'd2,
    ST_RUN         = 3'd3,
    ST_STEP_MODE   = 3'd4,
    ST_DONE        = 3'd5
  } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs received bytes LSB-first into LEN-bit words; pulses word_valid with the completed word.
module word_assembler #(
  parameter int unsigned LEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           byte_valid,
  input  logic [7:0]     byte_data,
  output logic [LEN-1:0] word,
  output logic           word_valid
);

  localparam int unsigned NBYTES = LEN / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned IDX_W  = CNT_W + 3;

  logic [CNT_W-1:0] byte_cnt;
  logic [LEN-1:0]   acc;
  logic [LEN-1:0]   lane_c;
  logic             last_c;

  // Partial word with the incoming byte dropped into its lane.
  always_comb begin
    lane_c = acc;
    lane_c[IDX_W'({byte_cnt, 3'b000}) +: 8] = byte_data;
    last_c = (byte_cnt == CNT_W'(NBYTES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      acc        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_cnt   <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        if (last_c) begin
          word       <= lane_c;
          word_valid <= 1'b1;
          acc        <= '0;
          byte_cnt   <= '0;
        end else begin
          acc      <= lane_c;
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debug_program_loader.sv
// Loads a program from the debug UART into instruction memory, then gates the pipeline.
// Optional byte echo to the UART transmitter: define DEBUG_PROGRAM_LOADER_ECHO_EN.
module debug_program_loader
  import debug_pkg::*;
#(
  parameter int unsigned LEN      = 32,
  parameter int unsigned ADDR_LEN = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done,
  input  logic                   halt_reached,
  output logic                   imem_we,
  output logic [ADDR_LEN-1:0]    imem_addr,
  output logic [LEN-1:0]         imem_data,
  output logic                   mips_enable,
  output logic                   mips_reset,
  output logic                   overflow,
  output logic [STATE_WIDTH-1:0] loader_state,
  output logic                   tx_start,
  output logic [7:0]             tx_data
);

  localparam logic [ADDR_LEN-1:0] ADDR_MAX = {ADDR_LEN{1'b1}};

  loader_state_e       state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                ovf_q, ovf_d;
  logic                en_q, en_d;
  logic                mrst_q, mrst_d;
  logic                clear_c;
  logic                byte_valid_c;
  logic [LEN-1:0]      wa_word;
  logic                wa_valid;

  word_assembler #(.LEN(LEN)) u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_c),
    .byte_valid (byte_valid_c),
    .byte_data  (rx_data),
    .word       (wa_word),
    .word_valid (wa_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      mrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      mrst_q  <= mrst_d;
    end
  end

  // Next state; mips_enable defaults low so any reset pulse also drops it.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ovf_d        = ovf_q;
    en_d         = 1'b0;
    mrst_d       = 1'b0;
    clear_c      = 1'b0;
    byte_valid_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_done && rx_data == CMD_START) begin
          state_d = ST_PROGRAMMING;
          addr_d  = '0;
          clear_c = 1'b1;
          mrst_d  = 1'b1;
        end
      end
      ST_PROGRAMMING: begin
        byte_valid_c = rx_done;
        if (wa_valid) begin
          if (wa_word[LEN-1 -: 6] == HALT_OPCODE) begin
            state_d = ST_WAIT_MODE;
            if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_LEN'(1);
          end else if (addr_q == ADDR_MAX) begin
            ovf_d   = 1'b1;
            state_d = ST_WAIT_MODE;
          end else begin
            addr_d = addr_q + ADDR_LEN'(1);
          end
        end
      end
      ST_WAIT_MODE: begin
        if (rx_done) begin
          case (rx_data)
            CMD_CONTINUOUS: begin
              state_d = ST_RUN;
              mrst_d  = 1'b1;
            end
            CMD_STEP_BY_STEP: begin
              state_d = ST_STEP_MODE;
              mrst_d  = 1'b1;
            end
            CMD_REPROGRAM: begin
              state_d = ST_PROGRAMMING;
              addr_d  = '0;
              ovf_d   = 1'b0;
              clear_c = 1'b1;
              mrst_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (halt_reached) state_d = ST_DONE;
        else              en_d    = 1'b1;
      end
      ST_STEP_MODE: begin
        if (rx_done && rx_data == CMD_REPROGRAM) begin
          state_d = ST_PROGRAMMING;
          addr_d  = '0;
          ovf_d   = 1'b0;
          clear_c = 1'b1;
          mrst_d  = 1'b1;
        end else if (halt_reached) begin
          state_d = ST_DONE;
        end else if (rx_done && rx_data == CMD_STEP) begin
          en_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (rx_done && rx_data == CMD_REPROGRAM) begin
          state_d = ST_PROGRAMMING;
          addr_d  = '0;
          ovf_d   = 1'b0;
          clear_c = 1'b1;
          mrst_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_we      = wa_valid;
  assign imem_data    = wa_word;
  assign imem_addr    = addr_q;
  assign mips_enable  = en_q;
  assign mips_reset   = mrst_q;
  assign overflow     = ovf_q;
  assign loader_state = state_q;

`ifdef DEBUG_PROGRAM_LOADER_ECHO_EN
  // Echo every received byte back one cycle later; data holds until the next echo.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= rx_done;
      if (rx_done) tx_data <= rx_data;
    end
  end
`else
  assign tx_start = 1'b0;
  assign tx_data  = '0;
`endif

endmodule

// File: tb/tb_debug_program_loader.sv
// Randomized bench for debug_program_loader against a byte-level behavioural model.
module tb_debug_program_loader;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  a_rx_data, b_rx_data;
  logic        a_rx_done, b_rx_done;
  logic        a_halt, b_halt;

  logic        a_imem_we, b_imem_we;
  logic [9:0]  a_imem_addr;
  logic [1:0]  b_imem_addr;
  logic [31:0] a_imem_data, b_imem_data;
  logic        a_en, b_en, a_mrst, b_mrst, a_ovf, b_ovf;
  logic [2:0]  a_state, b_state;
  logic        a_tx_start, b_tx_start;
  logic [7:0]  a_tx_data, b_tx_data;

  debug_program_loader #(.LEN(32), .ADDR_LEN(10)) dut_a (
    .clk(clk), .reset(reset), .rx_data(a_rx_data), .rx_done(a_rx_done),
    .halt_reached(a_halt), .imem_we(a_imem_we), .imem_addr(a_imem_addr),
    .imem_data(a_imem_data), .mips_enable(a_en), .mips_reset(a_mrst),
    .overflow(a_ovf), .loader_state(a_state), .tx_start(a_tx_start), .tx_data(a_tx_data)
  );

  debug_program_loader #(.LEN(32), .ADDR_LEN(2)) dut_b (
    .clk(clk), .reset(reset), .rx_data(b_rx_data), .rx_done(b_rx_done),
    .halt_reached(b_halt), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
    .imem_data(b_imem_data), .mips_enable(b_en), .mips_reset(b_mrst),
    .overflow(b_ovf), .loader_state(b_state), .tx_start(b_tx_start), .tx_data(b_tx_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic, sampled mid-cycle.
  wr_t got_a[$];
  wr_t got_b[$];
  int  en_a = 0, en_b = 0, mrst_a = 0, mrst_b = 0;
  always @(negedge clk) begin
    if (a_imem_we) got_a.push_back('{cyc: cyc, addr: int'(a_imem_addr), data: a_imem_data});
    if (b_imem_we) got_b.push_back('{cyc: cyc, addr: int'(b_imem_addr), data: b_imem_data});
    if (a_en)   en_a++;
    if (b_en)   en_b++;
    if (a_mrst) mrst_a++;
    if (b_mrst) mrst_b++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: loader mode, partial word, next address, expected writes.
  int          sel;
  int          m_state, m_addr, m_nb, m_depth, m_ovf, m_en;
  int          m_rst[2];
  logic [31:0] m_word;
  wr_t         exp_q[$];

  task automatic model_reset(input int depth);
    m_state = 0; m_addr = 0; m_nb = 0; m_ovf = 0; m_word = '0; m_depth = depth;
  endtask

  task automatic model_reprogram();
    m_state = 1; m_addr = 0; m_nb = 0; m_ovf = 0; m_word = '0; m_rst[sel]++;
  endtask

  task automatic model_byte(input logic [7:0] b, input int wc);
    case (m_state)
      0: if (b == 8'h01) begin
           m_state = 1; m_addr = 0; m_nb = 0; m_word = '0; m_rst[sel]++;
         end
      1: begin
           m_word[8*m_nb +: 8] = b;
           m_nb++;
           if (m_nb == 4) begin
             exp_q.push_back('{cyc: wc, addr: m_addr, data: m_word});
             if (m_word[31:26] == 6'h3F) m_state = 2;
             else if (m_addr == m_depth - 1) begin m_ovf = 1; m_state = 2; end
             else m_addr++;
             m_nb = 0; m_word = '0;
           end
         end
      2: begin
           if (b == 8'h02) begin m_state = 3; m_rst[sel]++; end
           else if (b == 8'h03) begin m_state = 4; m_rst[sel]++; end
           else if (b == 8'h05) model_reprogram();
         end
      4: begin
           if (b == 8'h06) m_en++;
           else if (b == 8'h05) model_reprogram();
         end
      5: if (b == 8'h05) model_reprogram();
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_byte(input logic [7:0] b);
    int c;
    c = cyc;
    if (sel == 0) begin a_rx_data = b; a_rx_done = 1'b1; end
    else          begin b_rx_data = b; b_rx_done = 1'b1; end
    @(posedge clk); #1;
    a_rx_done = 1'b0;
    b_rx_done = 1'b0;
    model_byte(b, c + 1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_after);
    for (int i = 0; i < 4; i++) begin
      put_byte(w[8*i +: 8]);
      if (i < 3) idle($urandom_range(0, 1));
    end
    idle(gap_after);
  endtask

  task automatic halt_pulse();
    if (sel == 0) a_halt = 1'b1; else b_halt = 1'b1;
    @(posedge clk); #1;
    a_halt = 1'b0;
    b_halt = 1'b0;
    if (m_state == 3 || m_state == 4) m_state = 5;
  endtask

  task automatic compare_writes(input string tag);
    wr_t g[$];
    if (sel == 0) begin g = got_a; got_a.delete(); end
    else          begin g = got_b; got_b.delete(); end
    check({tag, "_nwrites"}, 64'(g.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < g.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(g[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s_data%0d", tag, i), 64'(g[i].data), 64'(exp_q[i].data));
      check($sformatf("%s_cyc%0d", tag, i),  64'(g[i].cyc),  64'(exp_q[i].cyc));
    end
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    if (sel == 0) begin
      check({tag, "_state"}, 64'(a_state), 64'(m_state));
      check({tag, "_ovf"},   64'(a_ovf),   64'(m_ovf));
      check({tag, "_mrst"},  64'(mrst_a),  64'(m_rst[0]));
    end else begin
      check({tag, "_state"}, 64'(b_state), 64'(m_state));
      check({tag, "_ovf"},   64'(b_ovf),   64'(m_ovf));
      check({tag, "_mrst"},  64'(mrst_b),  64'(m_rst[1]));
    end
  endtask

  function automatic logic [31:0] rand_data_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  function automatic logic [7:0] rand_noise(input logic [7:0] avoid0, input logic [7:0] avoid1);
    logic [7:0] b;
    b = 8'($urandom_range(7, 255));
    if (b == avoid0 || b == avoid1) b = 8'h44;
    return b;
  endfunction

  initial begin
    int base, nw;
    logic [31:0] w;
    reset = 1'b1;
    a_rx_data = '0; b_rx_data = '0; a_rx_done = 1'b0; b_rx_done = 1'b0;
    a_halt = 1'b0; b_halt = 1'b0;
    sel = 0; m_en = 0; m_rst[0] = 0; m_rst[1] = 0;
    model_reset(1024);
    idle(3);
    reset = 1'b0;

    check("rst_we",    64'(a_imem_we),   64'd0);
    check("rst_addr",  64'(a_imem_addr), 64'd0);
    check("rst_data",  64'(a_imem_data), 64'd0);
    check("rst_en",    64'(a_en),        64'd0);
    check("rst_mrst",  64'(a_mrst),      64'd0);
    check("rst_tx",    64'(a_tx_start),  64'd0);
    check_state("rst");

    // Echo of a byte ignored in IDLE.
    put_byte(8'hA5);
`ifdef DEBUG_PROGRAM_LOADER_ECHO_EN
    check("echo_start", 64'(a_tx_start), 64'd1);
    check("echo_data",  64'(a_tx_data),  64'hA5);
    idle(1);
    check("echo_start_end", 64'(a_tx_start), 64'd0);
    check("echo_data_hold", 64'(a_tx_data),  64'hA5);
`else
    check("echo_start", 64'(a_tx_start), 64'd0);
    check("echo_data",  64'(a_tx_data),  64'd0);
    idle(1);
    check("echo_start_end", 64'(a_tx_start), 64'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      put_byte(rand_noise(8'h01, 8'h01));
      idle($urandom_range(0, 2));
    end
    check_state("idle_noise");

    // Directed load; the first byte of word 2 lands on the imem_we cycle.
    put_byte(8'h01);
    idle(1);
    send_word(32'h12345678, 0);
    send_word(32'hFCFFFFFF, 2);
    compare_writes("load");
    check_state("load");

    // Continuous run, halt after 50 enabled cycles; REPROGRAM in RUN is ignored.
    put_byte(8'h02);
    base = en_a;
    idle(20);
    put_byte(8'h05);
    idle(29);
    halt_pulse();
    check("run_en_cycles", 64'(en_a - base), 64'd50);
    check("run_en_off", 64'(a_en), 64'd0);
    check_state("run");

    // DONE ignores CONTINUOUS; REPROGRAM loads a random program ending in HALT.
    put_byte(8'h02);
    idle(1);
    put_byte(8'h05);
    idle(1);
    nw = $urandom_range(3, 6);
    for (int i = 0; i < nw; i++) send_word(rand_data_word(), $urandom_range(0, 2));
    w = $urandom;
    w[31:26] = 6'h3F;
    send_word(w, 2);
    compare_writes("reprog");
    check_state("reprog");

    // Step mode: three STEPs among ignored bytes.
    put_byte(8'h03);
    base = en_a;
    m_en = 0;
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(1, 3));
      put_byte(rand_noise(8'h05, 8'h06));
      idle($urandom_range(1, 3));
      put_byte(8'h06);
    end
    idle(3);
    check("step_en_cycles", 64'(en_a - base), 64'(m_en));
    check("step_en_count3", 64'(en_a - base), 64'd3);
    check("step_en_off", 64'(a_en), 64'd0);
    halt_pulse();
    idle(1);
    check_state("step_halt");

    // Reset mid-word, then a fresh single word.
    put_byte(8'h05);
    put_byte(8'hDE);
    put_byte(8'hAD);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_reset(1024);
    check("midrst_addr", 64'(a_imem_addr), 64'd0);
    check_state("midrst");
    put_byte(8'h01);
    send_word(32'h0BADF00D, 2);
    compare_writes("midrst_load");
    check_state("midrst_load");

    // Overflow on the 4-word memory.
    sel = 1;
    model_reset(4);
    got_b.delete();
    put_byte(8'h01);
    for (int i = 0; i < 4; i++) send_word(rand_data_word(), (i == 3) ? 2 : $urandom_range(0, 1));
    for (int i = 0; i < 4; i++) put_byte(rand_noise(8'h02, 8'h05) == 8'h03 ? 8'h77 : rand_noise(8'h02, 8'h05));
    idle(2);
    compare_writes("ovf");
    check_state("ovf");
    check("ovf_set", 64'(b_ovf), 64'd1);
    put_byte(8'h05);
    idle(1);
    check_state("ovf_clear");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
